obstacle_stepper: RTL
=====================

Name: obstacle_stepper

Overview:
- Consumes the one-cycle movement tick `mv` from the game tick counter and advances one falling obstacle down the VGA playfield.
- Spawns each obstacle at a pseudo-random x position, detects collision with the player sprite, and counts dodged obstacles.
- Outputs feed the VGA pixel renderer and the top-level game FSM.

Parameters:
- H_RES, 640, playfield width in pixels
- V_RES, 480, playfield height in pixels
- OBJ_W, 32, obstacle width in pixels
- OBJ_H, 32, obstacle height in pixels
- PLY_Y, 440, fixed top y of the player sprite
- PLY_W, 32, player width in pixels
- PLY_H, 32, player height in pixels
- STEP, 4, pixels moved per `mv` tick (1..15)

Ports:
- clk  in  1  system clock, same domain as the tick counter
- rst  in  1  synchronous reset, active-high
- current_state  in  1  1 = game running, 0 = menu/stopped
- mv  in  1  single-cycle movement tick
- player_x  in  10  left x of the player sprite
- obj_x  out  10  left x of the obstacle
- obj_y  out  10  top y of the obstacle
- obj_valid  out  1  obstacle is drawn
- hit  out  1  one-cycle pulse on collision
- score  out  8  obstacles dodged, saturating

Behaviour:
- Reset: all outputs are 0 (`obj_x`, `obj_y`, `obj_valid`, `hit`, `score`). FSM = IDLE. LFSR = 10'h001.
  - Reset takes priority on every edge, including mid-fall or while in HIT.
- LFSR:
  - 10-bit Fibonacci, taps at bits 10 and 7 (x^10+x^7+1).
  - Shifts every cycle, regardless of state.
  - Never reaches all-zero.
- Spawn x:
  - Let R = lfsr, M = H_RES-OBJ_W (608).
  - x = R if R < M, else R-M.
  - A single subtraction is sufficient because 1023-608 < 608.
- FSM states: IDLE, SPAWN, FALL, HIT.
- IDLE:
  - `obj_valid`=0 and `hit`=0.
  - When `current_state`=1, clear `score` to 0 and go to SPAWN on the next cycle.
- SPAWN (one cycle):
  - `obj_y`<=0, `obj_x`<=spawn x, `obj_valid`<=1, then go to FALL.
  - An `mv` arriving during SPAWN is ignored.
- FALL, on `mv`=1:
  - If `obj_y`+STEP > V_RES-OBJ_H (using 11-bit arithmetic): obstacle is dodged. `score`<=`score`+1, saturating at 255. Go to SPAWN.
  - Otherwise: `obj_y`<=`obj_y`+STEP.
- FALL, every cycle (collision check):
  - Collision evaluated on the registered position.
  - Overlap condition: `obj_x` < `player_x`+PLY_W AND `player_x` < `obj_x`+OBJ_W AND `obj_y`+OBJ_H > PLY_Y AND `obj_y` < PLY_Y+PLY_H.
  - On overlap: `hit`<=1 for exactly one cycle, go to HIT.
  - Collision has priority over an `mv` in the same cycle: position is frozen and `score` is not incremented.
- HIT:
  - Obstacle frozen, `obj_valid` stays 1.
  - `mv` is ignored.
  - Stay in HIT until `current_state`=0.
- Any state with `current_state`=0:
  - Go to IDLE on the next edge; `obj_valid`<=0.
  - `score` holds its value until the next game start.
- Latency: `mv` to updated `obj_y` is 1 cycle. Collision to `hit` is 1 cycle.
- Additions are widened by 1 bit; no wrap-around of `obj_y` is permitted.

Optional Feature:
- Macro: OBSTACLE_SPEEDUP_EN.
- Defined:
  - Effective step = STEP + `score`[7:3], capped at 15.
  - The step increases by 1 every 8 dodges.
  - The step is sampled when each move is applied.
- Undefined: step is the constant STEP and the `score`[7:3] logic is absent.

Test Plan:
- Reset hold with `current_state`=1 and `mv` pulses applied -> all outputs 0, FSM stays IDLE.
- `current_state` 0->1 with `player_x`=0 -> SPAWN one cycle later. `obj_y`=0, `obj_valid`=1, `obj_x` < 608 and equal to the LFSR-derived value from the reference model.
- 112 `mv` pulses, player far away (`player_x`=608 with `obj_x` < 576) -> `obj_y` reaches 448. Next `mv` gives `score`=1 and a respawn at `obj_y`=0.
- `player_x` = `obj_x`, ticks until `obj_y`+32 > 440 -> `hit` high exactly 1 cycle. Further `mv` leaves `obj_y` unchanged and `score` unchanged.
- Collision and `mv` in the same cycle -> `hit`=1, no `obj_y` update. Then `current_state`=0 -> `obj_valid`=0 next cycle, FSM IDLE, `score` retained.
- Force `score`=255 via 255 dodges, then one more dodge -> `score` stays 255. With OBSTACLE_SPEEDUP_EN defined, the step observed is 15 (cap).

Source files
------------

// File: rtl/obstacle_stepper.sv
// Falling-obstacle engine: LFSR spawn position, mv-driven descent, player collision and dodge score.
// Optional OBSTACLE_SPEEDUP_EN: step grows with score[7:3], capped at 15 pixels per tick.
module obstacle_stepper #(
    parameter int unsigned H_RES = 640,
    parameter int unsigned V_RES = 480,
    parameter int unsigned OBJ_W = 32,
    parameter int unsigned OBJ_H = 32,
    parameter int unsigned PLY_Y = 440,
    parameter int unsigned PLY_W = 32,
    parameter int unsigned PLY_H = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       current_state,
    input  logic       mv,
    input  logic [9:0] player_x,
    output logic [9:0] obj_x,
    output logic [9:0] obj_y,
    output logic       obj_valid,
    output logic       hit,
    output logic [7:0] score
);

    localparam int unsigned POS_W   = 10;
    localparam int unsigned SUM_W   = POS_W + 1;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned STEP_W  = 4;

    localparam logic [POS_W-1:0]   SPAWN_M   = POS_W'(H_RES - OBJ_W);
    localparam logic [SUM_W-1:0]   Y_LIMIT   = SUM_W'(V_RES - OBJ_H);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPAWN = 2'd1,
        FALL  = 2'd2,
        HIT   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [POS_W-1:0]   r_lfsr;
    logic [POS_W-1:0]   r_obj_x;
    logic [POS_W-1:0]   r_obj_y;
    logic               r_obj_valid;
    logic               r_hit;
    logic [SCORE_W-1:0] r_score;

    logic [POS_W-1:0]   w_obj_x_nxt;
    logic [POS_W-1:0]   w_obj_y_nxt;
    logic               w_obj_valid_nxt;
    logic               w_hit_nxt;
    logic [SCORE_W-1:0] w_score_nxt;

    logic [POS_W-1:0]   w_spawn_x;
    logic [STEP_W-1:0]  w_step;
    logic [SUM_W-1:0]   w_y_moved;
    logic               w_dodge;
    logic [SCORE_W-1:0] w_score_inc;
    logic               w_overlap;

    // x^10 + x^7 + 1 Fibonacci LFSR; free-running from reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= POS_W'(1);
        end else begin
            r_lfsr <= {r_lfsr[POS_W-2:0], r_lfsr[9] ^ r_lfsr[6]};
        end
    end

    // One conditional subtraction folds the full LFSR range into [0, SPAWN_M)
    assign w_spawn_x = (r_lfsr < SPAWN_M) ? r_lfsr : (r_lfsr - SPAWN_M);

`ifdef OBSTACLE_SPEEDUP_EN
    logic [5:0] w_step_sum;
    assign w_step_sum = 6'(STEP) + 6'(r_score[7:3]);
    assign w_step     = (w_step_sum > 6'd15) ? 4'd15 : w_step_sum[STEP_W-1:0];
`else
    assign w_step = STEP_W'(STEP);
`endif

    assign w_y_moved   = {1'b0, r_obj_y} + SUM_W'(w_step);
    assign w_dodge     = (w_y_moved > Y_LIMIT);
    assign w_score_inc = (r_score == SCORE_MAX) ? r_score : (r_score + SCORE_W'(1));

    // Axis-aligned box overlap on registered positions, all sums widened
    assign w_overlap = ({1'b0, r_obj_x} < ({1'b0, player_x} + SUM_W'(PLY_W)))
                    && ({1'b0, player_x} < ({1'b0, r_obj_x} + SUM_W'(OBJ_W)))
                    && (({1'b0, r_obj_y} + SUM_W'(OBJ_H)) > SUM_W'(PLY_Y))
                    && ({1'b0, r_obj_y} < SUM_W'(PLY_Y + PLY_H));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_obj_x     <= '0;
            r_obj_y     <= '0;
            r_obj_valid <= 1'b0;
            r_hit       <= 1'b0;
            r_score     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_obj_x     <= w_obj_x_nxt;
            r_obj_y     <= w_obj_y_nxt;
            r_obj_valid <= w_obj_valid_nxt;
            r_hit       <= w_hit_nxt;
            r_score     <= w_score_nxt;
        end
    end

    // Stopping the game overrides every state; collision outranks mv in FALL
    always_comb begin
        w_state_nxt     = r_state;
        w_obj_x_nxt     = r_obj_x;
        w_obj_y_nxt     = r_obj_y;
        w_obj_valid_nxt = r_obj_valid;
        w_hit_nxt       = 1'b0;
        w_score_nxt     = r_score;

        if (!current_state) begin
            w_state_nxt     = IDLE;
            w_obj_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_obj_valid_nxt = 1'b0;
                    w_score_nxt     = '0;
                    w_state_nxt     = SPAWN;
                end
                SPAWN: begin
                    w_obj_x_nxt     = w_spawn_x;
                    w_obj_y_nxt     = '0;
                    w_obj_valid_nxt = 1'b1;
                    w_state_nxt     = FALL;
                end
                FALL: begin
                    if (w_overlap) begin
                        w_hit_nxt   = 1'b1;
                        w_state_nxt = HIT;
                    end else if (mv) begin
                        if (w_dodge) begin
                            w_score_nxt = w_score_inc;
                            w_state_nxt = SPAWN;
                        end else begin
                            w_obj_y_nxt = w_y_moved[POS_W-1:0];
                        end
                    end
                end
                HIT: begin
                    w_state_nxt = HIT;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign obj_x     = r_obj_x;
    assign obj_y     = r_obj_y;
    assign obj_valid = r_obj_valid;
    assign hit       = r_hit;
    assign score     = r_score;

endmodule
